// File: rtl/cpu_pkg.sv
// cpu_pkg: cpustate and FSM state encodings shared by the mode controller
package cpu_pkg;

    localparam logic [1:0] CPUSTATE_IDLE  = 2'b00;
    localparam logic [1:0] CPUSTATE_IN    = 2'b01;
    localparam logic [1:0] CPUSTATE_CHECK = 2'b10;
    localparam logic [1:0] CPUSTATE_RUN   = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_IN      = 3'd1;
    localparam logic [2:0] S_IN_WR   = 3'd2;
    localparam logic [2:0] S_CHK     = 3'd3;
    localparam logic [2:0] S_CHK_RD  = 3'd4;
    localparam logic [2:0] S_CHK_CAP = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;

    function automatic logic [1:0] mode_of(input logic [2:0] s);
        return (s == S_IN || s == S_IN_WR) ? CPUSTATE_IN :
               (s == S_CHK || s == S_CHK_RD || s == S_CHK_CAP) ? CPUSTATE_CHECK :
               (s == S_RUN) ? CPUSTATE_RUN : CPUSTATE_IDLE;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer plus stability counter; one-cycle pulse on each debounced press
module key_debounce #(
    parameter int DEB_CYCLES = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // debounced level flips after DEB_CYCLES consecutive disagreeing samples; rising flip pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            pulse <= 1'b0;
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                pulse <= sync[1];
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_mode_ctrl.sv
// cpu_mode_ctrl: front-panel mode FSM, program loader/checker and memory port ownership
// Optional: CPU_MODE_CTRL_ADDR_LOAD_EN adds addr_sw/addr_key for direct address loading
module cpu_mode_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DEB_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_sw,
    input  logic              step_key,
    input  logic [7:0]        data_sw,
    input  logic [7:0]        mem_rdata,
`ifdef CPU_MODE_CTRL_ADDR_LOAD_EN
    input  logic [ADDR_W-1:0] addr_sw,
    input  logic              addr_key,
`endif
    output logic [1:0]        cpustate,
    output logic              cpu_rst_n,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [7:0]        ld_wdata,
    output logic              ld_we,
    output logic              ld_re,
    output logic [7:0]        chk_data,
    output logic              busy
);

    logic [1:0]        mode_q1, mode_s;
    logic [2:0]        state, nxt;
    logic              step_p, addr_p, chg;
    logic [ADDR_W-1:0] addr_val;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (.clk(clk), .rst(rst), .key(step_key), .pulse(step_p));

`ifdef CPU_MODE_CTRL_ADDR_LOAD_EN
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_addr (.clk(clk), .rst(rst), .key(addr_key), .pulse(addr_p));
    assign addr_val = addr_sw;
`else
    assign addr_p   = 1'b0;
    assign addr_val = '0;
`endif

    assign chg = mode_s != cpustate;

    // two-stage synchronizer for the raw mode switches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q1 <= CPUSTATE_IDLE;
            mode_s  <= CPUSTATE_IDLE;
        end else begin
            mode_q1 <= mode_sw;
            mode_s  <= mode_q1;
        end
    end

    // next state: mode changes detour through one idle cycle; address load beats a step press
    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:    nxt = (mode_s == CPUSTATE_IN) ? S_IN : (mode_s == CPUSTATE_CHECK) ? S_CHK :
                             (mode_s == CPUSTATE_RUN) ? S_RUN : S_IDLE;
            S_IN:      nxt = chg ? S_IDLE : (step_p && !addr_p) ? S_IN_WR : S_IN;
            S_IN_WR:   nxt = S_IN;
            S_CHK:     nxt = chg ? S_IDLE : (step_p && !addr_p) ? S_CHK_RD : S_CHK;
            S_CHK_RD:  nxt = S_CHK_CAP;
            S_CHK_CAP: nxt = S_CHK;
            S_RUN:     nxt = chg ? S_IDLE : S_RUN;
            default:   nxt = S_IDLE;
        endcase
    end

    // state register with all outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cpustate  <= CPUSTATE_IDLE;
            cpu_rst_n <= 1'b0;
            mem_sel   <= 1'b1;
            ld_addr   <= '0;
            ld_wdata  <= '0;
            ld_we     <= 1'b0;
            ld_re     <= 1'b0;
            chk_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            cpustate  <= mode_of(nxt);
            cpu_rst_n <= nxt == S_RUN;
            mem_sel   <= nxt != S_RUN;
            ld_we     <= nxt == S_IN_WR;
            ld_re     <= nxt == S_CHK_RD;
            busy      <= nxt == S_IN_WR || nxt == S_CHK_RD || nxt == S_CHK_CAP;
            if (state == S_IN && nxt == S_IN_WR)
                ld_wdata <= data_sw;
            if (state == S_CHK_CAP)
                chk_data <= mem_rdata;
            if (state == S_IDLE && (nxt == S_IN || nxt == S_CHK))
                ld_addr <= '0;
            else if (state == S_IN_WR || state == S_CHK_CAP)
                ld_addr <= ld_addr + 1'b1;
            else if ((state == S_IN || state == S_CHK) && !chg && addr_p)
                ld_addr <= addr_val;
        end
    end

endmodule

// File: tb/tb_cpu_mode_ctrl.sv
// tb_cpu_mode_ctrl: directed checks of reset, load, check, wrap and mode switching
module tb_cpu_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode_sw = 2'b00;
    logic        step_key = 1'b0;
    logic [7:0]  data_sw = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  rd_val = 8'h00;
    logic [1:0]  cpustate, s_cpustate;
    logic        cpu_rst_n, mem_sel, ld_we, ld_re, busy;
    logic        s_cpu_rst_n, s_mem_sel, s_ld_we, s_ld_re, s_busy;
    logic [15:0] ld_addr;
    logic [1:0]  s_ld_addr;
    logic [7:0]  ld_wdata, chk_data, s_ld_wdata, s_chk_data;
`ifdef CPU_MODE_CTRL_ADDR_LOAD_EN
    logic [15:0] addr_sw = 16'h0000;
    logic        addr_key = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, re_cnt = 0, s_wr_cnt = 0;
    logic [15:0] last_waddr = '0, last_raddr = '0;
    logic [7:0]  last_wdata = '0;
    logic [1:0]  s_last_waddr = '0;

    always #5 clk = ~clk;

    cpu_mode_ctrl #(.ADDR_W(16), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mode_sw(mode_sw), .step_key(step_key), .data_sw(data_sw),
        .mem_rdata(mem_rdata),
`ifdef CPU_MODE_CTRL_ADDR_LOAD_EN
        .addr_sw(addr_sw), .addr_key(addr_key),
`endif
        .cpustate(cpustate), .cpu_rst_n(cpu_rst_n), .mem_sel(mem_sel), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_we(ld_we), .ld_re(ld_re), .chk_data(chk_data), .busy(busy)
    );

    cpu_mode_ctrl #(.ADDR_W(2), .DEB_CYCLES(4)) dut_small (
        .clk(clk), .rst(rst), .mode_sw(mode_sw), .step_key(step_key), .data_sw(data_sw),
        .mem_rdata(mem_rdata),
`ifdef CPU_MODE_CTRL_ADDR_LOAD_EN
        .addr_sw(addr_sw[1:0]), .addr_key(addr_key),
`endif
        .cpustate(s_cpustate), .cpu_rst_n(s_cpu_rst_n), .mem_sel(s_mem_sel), .ld_addr(s_ld_addr),
        .ld_wdata(s_ld_wdata), .ld_we(s_ld_we), .ld_re(s_ld_re), .chk_data(s_chk_data), .busy(s_busy)
    );

    always @(posedge clk) mem_rdata <= ld_re ? rd_val : 8'hEE;

    always @(posedge clk) begin
        if (ld_we) begin
            wr_cnt++;
            last_waddr = ld_addr;
            last_wdata = ld_wdata;
        end
        if (ld_re) begin
            re_cnt++;
            last_raddr = ld_addr;
        end
        if (s_ld_we) begin
            s_wr_cnt++;
            s_last_waddr = s_ld_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        step_key = 1'b1;
        cyc(8);
        step_key = 1'b0;
        cyc(8);
    endtask

`ifdef CPU_MODE_CTRL_ADDR_LOAD_EN
    task automatic press_addr();
        addr_key = 1'b1;
        cyc(8);
        addr_key = 1'b0;
        cyc(8);
    endtask
`endif

    initial begin
        int found, idle, bad, w0, sw0;
        cyc(3);
        chk("rst_cpustate", 32'(cpustate), 32'h0);
        chk("rst_mem_sel", 32'(mem_sel), 32'h1);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        rst = 1'b0;
        mode_sw = 2'b01;
        cyc(6);
        chk("in_cpustate", 32'(cpustate), 32'h1);
        chk("in_ld_addr", 32'(ld_addr), 32'h0);

        data_sw = 8'h11;
        step_key = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (ld_we) found = 1;
        end
        chk("t1_we_seen", 32'(found), 32'h1);
        rst = 1'b1;
        #1;
        chk("t1_we", 32'(ld_we), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_cpustate", 32'(cpustate), 32'h0);
        chk("t1_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        chk("t1_mem_sel", 32'(mem_sel), 32'h1);
        chk("t1_ld_addr", 32'(ld_addr), 32'h0);
        chk("t1_ld_wdata", 32'(ld_wdata), 32'h0);
        chk("t1_ld_re", 32'(ld_re), 32'h0);
        chk("t1_chk_data", 32'(chk_data), 32'h0);
        step_key = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(12);
        chk("t1_no_write", 32'(wr_cnt), 32'h0);
        chk("t1_back_in", 32'(cpustate), 32'h1);

        data_sw = 8'hA5;
        press();
        chk("t2_wr_cnt", 32'(wr_cnt), 32'h1);
        chk("t2_waddr", 32'(last_waddr), 32'h0);
        chk("t2_wdata", 32'(last_wdata), 32'hA5);
        chk("t2_ld_addr", 32'(ld_addr), 32'h1);
        step_key = 1'b1;
        cyc(2);
        step_key = 1'b0;
        cyc(10);
        chk("t2_glitch_wr_cnt", 32'(wr_cnt), 32'h1);
        chk("t2_glitch_ld_addr", 32'(ld_addr), 32'h1);

        mode_sw = 2'b10;
        cyc(6);
        chk("t3_cpustate", 32'(cpustate), 32'h2);
        chk("t3_ld_addr0", 32'(ld_addr), 32'h0);
        rd_val = 8'h3C;
        press();
        chk("t3_re_cnt", 32'(re_cnt), 32'h1);
        chk("t3_raddr", 32'(last_raddr), 32'h0);
        chk("t3_chk_data", 32'(chk_data), 32'h3C);
        chk("t3_ld_addr", 32'(ld_addr), 32'h1);
        chk("t3_no_write", 32'(wr_cnt), 32'h1);

        mode_sw = 2'b01;
        cyc(6);
        chk("t4_ld_addr0", 32'(ld_addr), 32'h0);
        press();
        press();
        press();
        chk("t4_small_addr3", 32'(s_ld_addr), 32'h3);
        sw0 = s_wr_cnt;
        press();
        chk("t4_small_wr", 32'(s_wr_cnt - sw0), 32'h1);
        chk("t4_small_waddr", 32'(s_last_waddr), 32'h3);
        chk("t4_small_wrap", 32'(s_ld_addr), 32'h0);
        chk("t4_main_addr", 32'(ld_addr), 32'h4);

        mode_sw = 2'b11;
        cyc(6);
        chk("t5_run_cpustate", 32'(cpustate), 32'h3);
        chk("t5_run_cpu_rst_n", 32'(cpu_rst_n), 32'h1);
        chk("t5_run_mem_sel", 32'(mem_sel), 32'h0);
        w0 = wr_cnt;
        idle = 0;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (cpustate == 2'b00) begin
                idle++;
                if (cpu_rst_n) bad = 1;
            end
            if (i == 0) step_key = 1'b1;
            if (i == 4) mode_sw = 2'b01;
        end
        step_key = 1'b0;
        cyc(8);
        chk("t5_idle_cycles", 32'(idle), 32'h1);
        chk("t5_idle_rst_n", 32'(bad), 32'h0);
        chk("t5_in_cpustate", 32'(cpustate), 32'h1);
        chk("t5_in_mem_sel", 32'(mem_sel), 32'h1);
        chk("t5_in_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        chk("t5_in_ld_addr", 32'(ld_addr), 32'h0);
        chk("t5_no_write", 32'(wr_cnt - w0), 32'h0);

`ifdef CPU_MODE_CTRL_ADDR_LOAD_EN
        addr_sw = 16'h0040;
        press_addr();
        chk("t6_addr_load", 32'(ld_addr), 32'h40);
        data_sw = 8'h5A;
        press();
        chk("t6_waddr", 32'(last_waddr), 32'h40);
        chk("t6_wdata", 32'(last_wdata), 32'h5A);
        chk("t6_ld_addr", 32'(ld_addr), 32'h41);
        addr_sw = 16'hFFFF;
        press_addr();
        chk("t6_addr_ffff", 32'(ld_addr), 32'hFFFF);
        press();
        chk("t6_waddr_ffff", 32'(last_waddr), 32'hFFFF);
        chk("t6_wrap", 32'(ld_addr), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
